// File: rtl/i2c_slave_regs.sv
// I2C slave exposing a byte-wide register file with an auto-incrementing pointer.
// Pad edges act 3 clocks after they occur; no clock stretching, SCL is never driven.
module i2c_slave_regs #(
  parameter logic [6:0] SLV_ADR  = 7'h10,
  parameter int         PTR_W    = 3,
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        scl_pad_i,
  input  logic                        sda_pad_i,
  output logic                        sda_pad_o,
  output logic                        sda_padoen_o,
  output logic [8*(2**PTR_W)-1:0]     regs_o,
  output logic                        wr_stb_o,
  output logic [PTR_W-1:0]            wr_adr_o,
  output logic                        busy_o
);
  localparam int N_REGS = 2**PTR_W;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADR_ACK, S_PTR, S_PTR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_scl_s1, r_scl_s2, r_scl_h;
  logic             r_sda_s1, r_sda_s2, r_sda_h;
  logic [7:0]       r_shift;
  logic [2:0]       r_cnt;
  logic             r_byte_done, r_rw, r_mack, r_oen, r_wr_stb, r_busy;
  logic [PTR_W-1:0] r_ptr, r_wr_adr;
  logic [7:0]       r_regs [N_REGS];

  logic             w_scl_rise, w_scl_fall, w_start, w_stop, w_adr_match;
  logic [PTR_W-1:0] w_ptr_inc;

  assign w_scl_rise  = r_scl_s2 & ~r_scl_h;
  assign w_scl_fall  = ~r_scl_s2 & r_scl_h;
  assign w_start     = ~r_sda_s2 & r_sda_h & r_scl_s2;
  assign w_stop      = r_sda_s2 & ~r_sda_h & r_scl_s2;
  assign w_adr_match = (r_shift[7:1] == SLV_ADR);
  assign w_ptr_inc   = r_ptr + 1'b1;

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = r_oen;
  assign wr_stb_o     = r_wr_stb;
  assign wr_adr_o     = r_wr_adr;
  assign busy_o       = r_busy;

  for (genvar k = 0; k < N_REGS; k++) begin : g_regs_o
    assign regs_o[8*k +: 8] = r_regs[k];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= S_IDLE;
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_h <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_h <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_scl_s1 <= scl_pad_i; r_scl_s2 <= r_scl_s1; r_scl_h <= r_scl_s2;
      r_sda_s1 <= sda_pad_i; r_sda_s2 <= r_sda_s1; r_sda_h <= r_sda_s2;
    end
  end

  // START/STOP override everything; otherwise the FSM only advances on SCL falls.
  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      w_state_nxt = S_ADDR;
    end else if (w_scl_fall) begin
      case (r_state)
        S_ADDR:    if (r_byte_done) w_state_nxt = w_adr_match ? S_ADR_ACK : S_IDLE;
        S_ADR_ACK: w_state_nxt = r_rw ? S_RD : S_PTR;
        S_PTR:     if (r_byte_done) w_state_nxt = S_PTR_ACK;
        S_PTR_ACK: w_state_nxt = S_WR;
        S_WR:      if (r_byte_done) w_state_nxt = S_WR_ACK;
        S_WR_ACK:  w_state_nxt = S_WR;
        S_RD:      if (r_byte_done) w_state_nxt = S_RD_ACK;
        S_RD_ACK:  w_state_nxt = r_mack ? S_IDLE : S_RD;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_shift     <= 8'h00;
      r_cnt       <= 3'd0;
      r_byte_done <= 1'b0;
      r_rw        <= 1'b0;
      r_mack      <= 1'b1;
      r_oen       <= 1'b1;
      r_wr_stb    <= 1'b0;
      r_wr_adr    <= '0;
      r_ptr       <= '0;
      r_busy      <= 1'b0;
      for (int k = 0; k < N_REGS; k++) r_regs[k] <= REG_INIT;
    end else begin
      r_wr_stb <= 1'b0;
      if (w_stop) begin
        r_oen  <= 1'b1;
        r_busy <= 1'b0;
      end else if (w_start) begin
        r_oen       <= 1'b1;
        r_cnt       <= 3'd0;
        r_byte_done <= 1'b0;
      end else if (w_scl_rise) begin
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) r_byte_done <= 1'b1;
        if (r_state != S_RD) r_shift <= {r_shift[6:0], r_sda_s2};
        if (r_state == S_RD_ACK) r_mack <= r_sda_s2;
      end else if (w_scl_fall) begin
        case (r_state)
          S_ADDR: if (r_byte_done) begin
            r_byte_done <= 1'b0;
            r_oen       <= ~w_adr_match;
            r_busy      <= w_adr_match;
            r_rw        <= r_shift[0];
          end
          S_ADR_ACK: begin
            r_cnt       <= 3'd0;
            r_byte_done <= 1'b0;
            if (r_rw) begin
              r_shift <= r_regs[r_ptr];
              r_oen   <= r_regs[r_ptr][7];
            end else begin
              r_oen <= 1'b1;
            end
          end
          S_PTR: if (r_byte_done) begin
            r_byte_done <= 1'b0;
            r_ptr       <= r_shift[PTR_W-1:0];
            r_oen       <= 1'b0;
          end
          S_PTR_ACK, S_WR_ACK: begin
            r_cnt       <= 3'd0;
            r_byte_done <= 1'b0;
            r_oen       <= 1'b1;
          end
          S_WR: if (r_byte_done) begin
            r_byte_done   <= 1'b0;
            r_regs[r_ptr] <= r_shift;
            r_wr_stb      <= 1'b1;
            r_wr_adr      <= r_ptr;
            r_ptr         <= w_ptr_inc;
            r_oen         <= 1'b0;
          end
          S_RD: begin
            if (r_byte_done) begin
              r_byte_done <= 1'b0;
              r_oen       <= 1'b1;
            end else begin
              r_shift <= {r_shift[6:0], 1'b0};
              r_oen   <= r_shift[6];
            end
          end
          S_RD_ACK: begin
            r_cnt       <= 3'd0;
            r_byte_done <= 1'b0;
            if (!r_mack) begin
              r_ptr   <= w_ptr_inc;
              r_shift <= r_regs[w_ptr_inc];
              r_oen   <= r_regs[w_ptr_inc][7];
            end else begin
              r_oen <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bit-banged I2C master driving i2c_slave_regs through table-driven writes
// and hand-written read, STOP-mid-byte and reset-mid-read sequences.
module tb_i2c_slave_regs;
  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rst, scl, m_sda;
  logic        sda_pad_o, sda_padoen_o, wr_stb_o, busy_o;
  logic [63:0] regs_o;
  logic [2:0]  wr_adr_o;
  logic        sda_line;

  int n_chk = 0;
  int n_fail = 0;

  assign sda_line = m_sda & (sda_padoen_o ? 1'b1 : sda_pad_o);

  i2c_slave_regs dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .scl_pad_i(scl), .sda_pad_i(sda_line),
    .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o), .regs_o(regs_o),
    .wr_stb_o(wr_stb_o), .wr_adr_o(wr_adr_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  logic [2:0] stb_adr_q[$];
  logic [7:0] stb_dat_q[$];
  always @(negedge clk) begin
    if (wr_stb_o) begin
      stb_adr_q.push_back(wr_adr_o);
      stb_dat_q.push_back(regs_o[8*wr_adr_o +: 8]);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_q(input int n);
    repeat (n*Q) @(negedge clk);
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; wait_q(1);
    scl = 1'b1;   wait_q(1);
    m_sda = 1'b0; wait_q(1);
    scl = 1'b0;   wait_q(1);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; wait_q(1);
    scl = 1'b1;   wait_q(1);
    m_sda = 1'b1; wait_q(1);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; wait_q(1);
    scl = 1'b1; wait_q(2);
    scl = 1'b0; wait_q(1);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked, output logic low_seen);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1;
    low_seen = 1'b0;
    repeat (Q) begin @(negedge clk); if (!sda_line) low_seen = 1'b1; end
    scl = 1'b1;
    repeat (Q) begin @(negedge clk); if (!sda_line) low_seen = 1'b1; end
    acked = !sda_line;
    repeat (Q) begin @(negedge clk); if (!sda_line) low_seen = 1'b1; end
    scl = 1'b0;
    wait_q(1);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; wait_q(1);
      scl = 1'b1;   wait_q(1);
      d[i] = sda_line; wait_q(1);
      scl = 1'b0;   wait_q(1);
    end
    m_sda = mack; wait_q(1);
    scl = 1'b1;   wait_q(2);
    scl = 1'b0;   wait_q(1);
    m_sda = 1'b1;
  endtask

  typedef struct {
    logic [7:0] adr, ptr, d0, d1;
    logic       exp_ack;
    int         exp_nstb;
    logic [2:0] i0, i1;
    logic [7:0] v0, v1;
  } wvec_t;

  wvec_t       vt[4];
  logic [63:0] exp_regs;

  initial begin
    #2ms;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       ack, low;
    logic [7:0] d;

    vt[0] = '{8'h20, 8'h03, 8'h5A, 8'hA5, 1'b1, 2, 3'd3, 3'd4, 8'h5A, 8'hA5};
    vt[1] = '{8'h20, 8'h07, 8'h11, 8'h22, 1'b1, 2, 3'd7, 3'd0, 8'h11, 8'h22};
    vt[2] = '{8'h22, 8'h01, 8'h33, 8'h44, 1'b0, 0, 3'd1, 3'd2, 8'h00, 8'h00};
    vt[3] = '{8'h20, 8'h0D, 8'hC3, 8'h3C, 1'b1, 2, 3'd5, 3'd6, 8'hC3, 8'h3C};

    rst = 1'b1; scl = 1'b1; m_sda = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check("rst_oen",   sda_padoen_o, 1'b1);
    check("rst_pad_o", sda_pad_o,    1'b0);
    check("rst_regs",  regs_o,       64'h0);
    check("rst_stb",   wr_stb_o,     1'b0);
    check("rst_adr",   wr_adr_o,     3'd0);
    check("rst_busy",  busy_o,       1'b0);
    exp_regs = 64'h0;
    wait_q(2);

    for (int i = 0; i < 4; i++) begin
      stb_adr_q.delete(); stb_dat_q.delete();
      i2c_start;
      write_byte(vt[i].adr, ack, low);
      check($sformatf("v%0d_adr_ack", i), ack, vt[i].exp_ack);
      if (!vt[i].exp_ack) check($sformatf("v%0d_sda_low", i), low, 1'b0);
      check($sformatf("v%0d_busy", i), busy_o, vt[i].exp_ack);
      write_byte(vt[i].ptr, ack, low);
      check($sformatf("v%0d_ptr_ack", i), ack, vt[i].exp_ack);
      write_byte(vt[i].d0, ack, low);
      check($sformatf("v%0d_d0_ack", i), ack, vt[i].exp_ack);
      write_byte(vt[i].d1, ack, low);
      check($sformatf("v%0d_d1_ack", i), ack, vt[i].exp_ack);
      i2c_stop;
      wait_q(1);
      check($sformatf("v%0d_busy_end", i), busy_o, 1'b0);
      check($sformatf("v%0d_nstb", i), stb_adr_q.size(), vt[i].exp_nstb);
      if (vt[i].exp_nstb == 2 && stb_adr_q.size() == 2) begin
        check($sformatf("v%0d_stb_adr0", i), stb_adr_q[0], vt[i].i0);
        check($sformatf("v%0d_stb_adr1", i), stb_adr_q[1], vt[i].i1);
        check($sformatf("v%0d_stb_dat0", i), stb_dat_q[0], vt[i].v0);
        check($sformatf("v%0d_stb_dat1", i), stb_dat_q[1], vt[i].v1);
        exp_regs[8*vt[i].i0 +: 8] = vt[i].v0;
        exp_regs[8*vt[i].i1 +: 8] = vt[i].v1;
      end
      check($sformatf("v%0d_regs", i), regs_o, exp_regs);
    end

    // Repeated-START read from 3, then wrap-around read from 7.
    stb_adr_q.delete();
    i2c_start; write_byte(8'h20, ack, low); write_byte(8'h03, ack, low);
    i2c_start; write_byte(8'h21, ack, low);
    check("rd3_adr_ack", ack, 1'b1);
    check("rd3_busy", busy_o, 1'b1);
    read_byte(1'b0, d); check("rd3_b0", d, 8'h5A);
    read_byte(1'b1, d); check("rd3_b1", d, 8'hA5);
    check("rd3_nack_rel", sda_padoen_o, 1'b1);
    i2c_stop; wait_q(1);
    check("rd3_busy_end", busy_o, 1'b0);
    check("rd3_nstb", stb_adr_q.size(), 0);

    i2c_start; write_byte(8'h20, ack, low); write_byte(8'h07, ack, low);
    i2c_start; write_byte(8'h21, ack, low);
    read_byte(1'b0, d); check("rd7_b0", d, 8'h11);
    read_byte(1'b1, d); check("rd7_b1", d, 8'h22);
    i2c_stop; wait_q(1);

    // STOP after 4 data bits: nothing written, slave back in IDLE.
    stb_adr_q.delete();
    i2c_start; write_byte(8'h20, ack, low); write_byte(8'h02, ack, low);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop; wait_q(1);
    check("stopmid_regs", regs_o, exp_regs);
    check("stopmid_nstb", stb_adr_q.size(), 0);
    check("stopmid_oen", sda_padoen_o, 1'b1);
    check("stopmid_busy", busy_o, 1'b0);
    scl = 1'b0; wait_q(1);
    write_byte(8'h20, ack, low);
    check("stopmid_idle_noack", ack, 1'b0);
    m_sda = 1'b1; scl = 1'b1; wait_q(1);

    // Reset while the slave drives the 0 MSB of regs[1].
    i2c_start; write_byte(8'h20, ack, low); write_byte(8'h01, ack, low);
    i2c_start; write_byte(8'h21, ack, low);
    check("rstrd_driving", sda_padoen_o, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstrd_oen", sda_padoen_o, 1'b1);
    check("rstrd_regs", regs_o, 64'h0);
    check("rstrd_busy", busy_o, 1'b0);
    i2c_stop; wait_q(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
